// File: rtl/cosine_arbiter.sv
// Two-port round-robin front end for a shared combinational cosine core.
// Holds each operand for SETTLE_CYCLES edges before sampling the core output.
module cosine_arbiter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_angle,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_angle,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_result,
  output logic        rsp0_err,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_result,
  output logic        rsp1_err,
  input  logic        rsp1_ready,
  output logic [31:0] cos_angle,
  input  logic [31:0] cos_result,
  output logic        busy
);

  localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      result;
  logic             err;

  logic        any_req;
  logic        grant;
  logic        rsp_taken;
  logic [31:0] grant_angle;
  logic        out_of_range;

  always_comb begin
    any_req = req0_valid | req1_valid;
    // On a tie the requester that did not win last time goes first.
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
    grant_angle  = grant ? req1_angle : req0_angle;
    // -0 is legal; exponent above 134 means >= 256, Inf or NaN.
    out_of_range = (grant_angle[31] && (|grant_angle[30:0])) ||
                   (grant_angle[30:23] > 8'd134);
    rsp_taken    = owner ? rsp1_ready : rsp0_ready;
  end

  assign req0_ready  = (state == IDLE) && any_req && !grant;
  assign req1_ready  = (state == IDLE) && any_req &&  grant;
  assign busy        = (state != IDLE);
  assign rsp0_result = result;
  assign rsp1_result = result;
  assign rsp0_err    = err;
  assign rsp1_err    = err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      cos_angle  <= '0;
      result     <= '0;
      err        <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= grant;
            last_grant <= grant;
            if (out_of_range) begin
              // Core operand is left untouched for illegal angles.
              result     <= QNAN;
              err        <= 1'b1;
              rsp0_valid <= ~grant;
              rsp1_valid <= grant;
              state      <= RESP;
            end else begin
              cos_angle <= grant_angle;
              cnt       <= '0;
              state     <= SETTLE;
            end
          end
        end
        SETTLE: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            result     <= cos_result;
            err        <= 1'b0;
            rsp0_valid <= ~owner;
            rsp1_valid <= owner;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_taken) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cosine_arbiter.sv
// Directed bench for cosine_arbiter: a SETTLE_CYCLES=2 instance with a core model
// that is only correct once its operand has been held, plus a SETTLE_CYCLES=1 instance.
module tb_cosine_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_angle, req1_angle;
  logic        rsp0_valid, rsp0_err, rsp0_ready, rsp1_valid, rsp1_err, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result, cos_angle, cos_result;
  logic        busy;

  logic        s1_req0_valid, s1_req0_ready, s1_req1_valid, s1_req1_ready;
  logic [31:0] s1_req0_angle, s1_req1_angle;
  logic        s1_rsp0_valid, s1_rsp0_err, s1_rsp0_ready, s1_rsp1_valid, s1_rsp1_err, s1_rsp1_ready;
  logic [31:0] s1_rsp0_result, s1_rsp1_result, s1_cos_angle, s1_cos_result;
  logic        s1_busy;

  cosine_arbiter #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_angle(req0_angle), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_angle(req1_angle), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err), .rsp1_ready(rsp1_ready),
    .cos_angle(cos_angle), .cos_result(cos_result), .busy(busy)
  );

  cosine_arbiter #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0_valid(s1_req0_valid), .req0_angle(s1_req0_angle), .req0_ready(s1_req0_ready),
    .req1_valid(s1_req1_valid), .req1_angle(s1_req1_angle), .req1_ready(s1_req1_ready),
    .rsp0_valid(s1_rsp0_valid), .rsp0_result(s1_rsp0_result), .rsp0_err(s1_rsp0_err), .rsp0_ready(s1_rsp0_ready),
    .rsp1_valid(s1_rsp1_valid), .rsp1_result(s1_rsp1_result), .rsp1_err(s1_rsp1_err), .rsp1_ready(s1_rsp1_ready),
    .cos_angle(s1_cos_angle), .cos_result(s1_cos_result), .busy(s1_busy)
  );

  // Cosine lookup for the angles used here (255 rad entry is cos(255) rounded).
  function automatic logic [31:0] cos_fn(input logic [31:0] a);
    case (a)
      32'h0000_0000, 32'h8000_0000: return 32'h3f80_0000;
      32'h3f80_0000:                return 32'h3f0a_5140;
      32'h3f00_0000:                return 32'h3f60_a940;
      32'h437f_0000:                return 32'hbf5c_bfef;
      default:                      return 32'h0bad_c0de;
    endcase
  endfunction

  // Core model: output is garbage until the operand has been held through one edge.
  logic [31:0] prev_angle;
  always @(posedge clk) prev_angle <= cos_angle;
  assign cos_result    = (cos_angle === prev_angle) ? cos_fn(cos_angle) : 32'hxxxx_xxxx;
  assign s1_cos_result = cos_fn(s1_cos_angle);

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_angle = '0; req1_angle = '0;
    s1_req0_valid = 0; s1_req1_valid = 0; s1_rsp0_ready = 0; s1_rsp1_ready = 0;
    s1_req0_angle = '0; s1_req1_angle = '0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (cos_angle !== 32'h0) begin errors++; $display("FAIL reset_cos_angle: got %h want 00000000", cos_angle); end
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", {rsp0_valid, rsp1_valid}); end
    checks++; if ({rsp0_result, rsp1_err, rsp0_err} !== 34'h0) begin errors++; $display("FAIL reset_rsp_data: got %h/%b%b want 0", rsp0_result, rsp1_err, rsp0_err); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready_idle: got %b want 00", {req0_ready, req1_ready}); end
    checks++; if (s1_busy !== 1'b0) begin errors++; $display("FAIL reset_s1_busy: got %b want 0", s1_busy); end
  endtask

  task automatic test_single;
    req0_valid = 1; req0_angle = 32'h3f80_0000;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
    tick;
    req0_valid = 0;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_drop: got %b want 0", req0_ready); end
    checks++; if (cos_angle !== 32'h3f80_0000 || busy !== 1'b1) begin errors++; $display("FAIL single_drive: got %h busy %b want 3f800000 busy 1", cos_angle, busy); end
    tick;
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", rsp0_valid); end
    tick;
    checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_valid: got %b%b want 10", rsp0_valid, rsp1_valid); end
    checks++; if (rsp0_result !== 32'h3f0a_5140 || rsp0_err !== 1'b0) begin errors++; $display("FAIL single_result: got %h err %b want 3f0a5140 err 0", rsp0_result, rsp0_err); end
    rsp0_ready = 1;
    tick;
    checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_handshake: got valid %b busy %b want 0 0", rsp0_valid, busy); end
    rsp0_ready = 0;
  endtask

  task automatic test_tie;
    do_reset;
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_angle = 32'h0000_0000;
    req1_valid = 1; req1_angle = 32'h3f00_0000;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL tie_first_grant: got %b want 10", {req0_ready, req1_ready}); end
    tick;
    req0_angle = 32'h3f80_0000;  // req0 immediately queues a second request
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL tie_busy_ready: got %b want 00", {req0_ready, req1_ready}); end
    tick; tick;
    checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_result !== 32'h3f80_0000) begin errors++; $display("FAIL tie_rsp0: got %b%b %h want 10 3f800000", rsp0_valid, rsp1_valid, rsp0_result); end
    tick;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL tie_second_grant: got %b want 01", {req0_ready, req1_ready}); end
    tick;
    req1_valid = 0;
    tick; tick;
    checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_result !== 32'h3f60_a940) begin errors++; $display("FAIL tie_rsp1: got %b%b %h want 01 3f60a940", rsp0_valid, rsp1_valid, rsp1_result); end
    tick;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL tie_third_grant: got %b want 10", {req0_ready, req1_ready}); end
    tick;
    req0_valid = 0;
    tick; tick;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h3f0a_5140) begin errors++; $display("FAIL tie_rsp0_again: got %b %h want 1 3f0a5140", rsp0_valid, rsp0_result); end
    tick;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_out_of_range;
    logic [31:0] oor [2];
    oor[0] = 32'hbf80_0000;
    oor[1] = 32'h4380_0000;
    rsp1_ready = 1;
    for (int i = 0; i < 2; i++) begin
      req1_valid = 1; req1_angle = oor[i];
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL oor_ready[%0d]: got %b want 1", i, req1_ready); end
      tick;
      req1_valid = 0;
      checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL oor_latency[%0d]: got %b%b want 01", i, rsp0_valid, rsp1_valid); end
      checks++; if (rsp1_result !== 32'h7fc0_0000 || rsp1_err !== 1'b1) begin errors++; $display("FAIL oor_result[%0d]: got %h err %b want 7fc00000 err 1", i, rsp1_result, rsp1_err); end
      checks++; if (cos_angle !== 32'h3f80_0000) begin errors++; $display("FAIL oor_core_held[%0d]: got %h want 3f800000", i, cos_angle); end
      tick;
      checks++; if (rsp1_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL oor_done[%0d]: got valid %b busy %b want 0 0", i, rsp1_valid, busy); end
    end
    req1_valid = 1; req1_angle = 32'h437f_0000;
    tick;
    req1_valid = 0;
    checks++; if (rsp1_valid !== 1'b0 || cos_angle !== 32'h437f_0000) begin errors++; $display("FAIL max_accept: got valid %b angle %h want 0 437f0000", rsp1_valid, cos_angle); end
    tick; tick;
    checks++; if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b0 || rsp1_result !== 32'hbf5c_bfef) begin errors++; $display("FAIL max_result: got %b err %b %h want 1 0 bf5cbfef", rsp1_valid, rsp1_err, rsp1_result); end
    tick;
    rsp1_ready = 0;
  endtask

  task automatic test_backpressure;
    req0_valid = 1; req0_angle = 32'h3f80_0000;
    tick;
    req0_valid = 0;
    req1_valid = 1; req1_angle = 32'h3f00_0000;
    tick; tick;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h3f0a_5140 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid %b result %h req1_ready %b busy %b want 1 3f0a5140 0 1", i, rsp0_valid, rsp0_result, req1_ready, busy);
      end
      tick;
    end
    rsp0_ready = 1;
    tick;
    rsp0_ready = 0;
    #1;
    checks++; if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid %b req1_ready %b want 0 1", rsp0_valid, req1_ready); end
    tick;
    req1_valid = 0;
    checks++; if (cos_angle !== 32'h3f00_0000 || busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept: got %h busy %b want 3f000000 1", cos_angle, busy); end
    rsp1_ready = 1;
    tick; tick;
    checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h3f60_a940) begin errors++; $display("FAIL bp_rsp1: got %b %h want 1 3f60a940", rsp1_valid, rsp1_result); end
    tick;
    rsp1_ready = 0;
  endtask

  task automatic test_reset_mid;
    req0_valid = 1; req0_angle = 32'h3f80_0000;
    tick;
    req0_valid = 0;
    tick;
    reset = 1;
    tick;
    reset = 0;
    checks++; if (busy !== 1'b0 || cos_angle !== 32'h0) begin errors++; $display("FAIL midreset_state: got busy %b angle %h want 0 00000000", busy, cos_angle); end
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL midreset_valid: got %b want 00", {rsp0_valid, rsp1_valid}); end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_no_rsp[%0d]: got valid %b busy %b want 0 0", i, rsp0_valid, busy); end
    end
    req1_valid = 1; req1_angle = 32'h3f00_0000;
    tick;
    req1_valid = 0;
    tick; tick;
    checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h3f60_a940 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL midreset_fresh: got %b%b %h want 01 3f60a940", rsp0_valid, rsp1_valid, rsp1_result); end
    rsp1_ready = 1;
    tick;
    rsp1_ready = 0;
  endtask

  task automatic test_settle1;
    s1_req0_valid = 1; s1_req0_angle = 32'h8000_0000;
    #1;
    checks++; if (s1_req0_ready !== 1'b1) begin errors++; $display("FAIL s1_ready: got %b want 1", s1_req0_ready); end
    tick;
    s1_req0_valid = 0;
    checks++; if (s1_rsp0_valid !== 1'b0 || s1_busy !== 1'b1 || s1_cos_angle !== 32'h8000_0000) begin errors++; $display("FAIL s1_accept: got valid %b busy %b angle %h want 0 1 80000000", s1_rsp0_valid, s1_busy, s1_cos_angle); end
    tick;
    checks++; if (s1_rsp0_valid !== 1'b1 || s1_rsp0_err !== 1'b0 || s1_rsp0_result !== 32'h3f80_0000) begin errors++; $display("FAIL s1_result: got %b err %b %h want 1 0 3f800000", s1_rsp0_valid, s1_rsp0_err, s1_rsp0_result); end
    s1_rsp0_ready = 1;
    tick;
    checks++; if (s1_rsp0_valid !== 1'b0 || s1_busy !== 1'b0) begin errors++; $display("FAIL s1_done: got valid %b busy %b want 0 0", s1_rsp0_valid, s1_busy); end
    s1_rsp0_ready = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_tie;
    test_out_of_range;
    test_backpressure;
    test_reset_mid;
    test_settle1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
